// File: rtl/cmd_executor.sv
// rtl/cmd_executor.sv - command buffer reader/decoder issuing bus writes and read-modify-writes
module cmd_executor #(
    parameter int                    CMD_WIDTH  = 64,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] END_ADDR   = 32'h0000_04A0,
    parameter int                    CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [1:0]            err_code,
    output logic [CNT_WIDTH-1:0]  cmd_cnt,
    output logic                  cmd_rd_en,
    output logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic                  cmd_rd_valid,
    input  logic [CMD_WIDTH-1:0]  cmd_out,
    output logic                  mst_o_valid,
    output logic [ADDR_WIDTH-1:0] mst_o_addr,
    output logic [DATA_WIDTH-1:0] mst_o_wr_data,
    output logic                  mst_o_rd0_wr1,
    input  logic                  mst_i_ready,
    input  logic [DATA_WIDTH-1:0] mst_i_rd_data,
    input  logic                  mst_i_rd_valid
);

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        WAIT_CMD,
        DECODE,
        ISSUE_WR,
        ISSUE_RD,
        WAIT_RD,
        DONE,
        ERROR
    } state_t;

    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_SEQ     = 2'b10;
    localparam logic [1:0] TR_WRITE    = 2'b00;

    state_t                 state;
    state_t                 state_nxt;
    logic [CMD_WIDTH-1:0]   cmd_reg;
    logic [DATA_WIDTH-1:0]  tmp;
    logic                   rmw_pend;
    logic                   set_err;
    logic [1:0]             err_val;

    logic [1:0]             cmd_trans;
    logic [DATA_WIDTH-1:0]  cmd_data;
    logic [ADDR_WIDTH-1:0]  cmd_baddr;
    logic                   at_end;

    // Field extraction from the latched command; the bus address is word aligned.
    assign cmd_trans = cmd_reg[1:0];
    assign cmd_data  = cmd_reg[DATA_WIDTH+1:2];
    assign cmd_baddr = {cmd_reg[CMD_WIDTH-1:DATA_WIDTH+2], 2'b00};
    assign at_end    = (cmd_addr == END_ADDR);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and Moore outputs; error codes are captured on entry to ERROR.
    always_comb begin
        state_nxt     = state;
        set_err       = 1'b0;
        err_val       = 2'b00;
        busy          = (state != IDLE);
        done          = 1'b0;
        err           = 1'b0;
        cmd_rd_en     = 1'b0;
        mst_o_valid   = 1'b0;
        mst_o_addr    = '0;
        mst_o_wr_data = '0;
        mst_o_rd0_wr1 = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                if (at_end) begin
                    if (rmw_pend) begin
                        state_nxt = ERROR;
                        set_err   = 1'b1;
                        err_val   = ERR_SEQ;
                    end else begin
                        state_nxt = DONE;
                    end
                end else begin
                    cmd_rd_en = 1'b1;
                    state_nxt = WAIT_CMD;
                end
            end
            WAIT_CMD: begin
                if (cmd_rd_valid) begin
                    state_nxt = DECODE;
                end
            end
            DECODE: begin
                if (cmd_reg == '0) begin
                    if (rmw_pend) begin
                        state_nxt = ERROR;
                        set_err   = 1'b1;
                        err_val   = ERR_SEQ;
                    end else begin
                        state_nxt = DONE;
                    end
                end else if (cmd_trans[1]) begin
                    state_nxt = ERROR;
                    set_err   = 1'b1;
                    err_val   = ERR_ILLEGAL;
                end else if (cmd_trans != TR_WRITE) begin
                    if (rmw_pend) begin
                        state_nxt = ERROR;
                        set_err   = 1'b1;
                        err_val   = ERR_SEQ;
                    end else begin
                        state_nxt = ISSUE_RD;
                    end
                end else begin
                    state_nxt = ISSUE_WR;
                end
            end
            ISSUE_RD: begin
                mst_o_valid = 1'b1;
                mst_o_addr  = cmd_baddr;
                if (mst_i_ready) begin
                    state_nxt = WAIT_RD;
                end
            end
            WAIT_RD: begin
                if (mst_i_rd_valid) begin
                    state_nxt = FETCH;
                end
            end
            ISSUE_WR: begin
                mst_o_valid   = 1'b1;
                mst_o_rd0_wr1 = 1'b1;
                mst_o_addr    = cmd_baddr;
                mst_o_wr_data = rmw_pend ? (tmp | cmd_data) : cmd_data;
                if (mst_i_ready) begin
                    state_nxt = FETCH;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            ERROR: begin
                err       = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Run datapath: fetch index, write counter, pending read-modify-write value and error code.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_addr <= '0;
            cmd_cnt  <= '0;
            err_code <= 2'b00;
            rmw_pend <= 1'b0;
            tmp      <= '0;
            cmd_reg  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cmd_addr <= '0;
                        cmd_cnt  <= '0;
                        err_code <= 2'b00;
                        rmw_pend <= 1'b0;
                    end
                end
                WAIT_CMD: begin
                    if (cmd_rd_valid) begin
                        cmd_reg <= cmd_out;
                    end
                end
                WAIT_RD: begin
                    if (mst_i_rd_valid) begin
                        tmp      <= mst_i_rd_data & cmd_data;
                        rmw_pend <= 1'b1;
                        cmd_addr <= cmd_addr + ADDR_WIDTH'(4);
                    end
                end
                ISSUE_WR: begin
                    if (mst_i_ready) begin
                        rmw_pend <= 1'b0;
                        cmd_addr <= cmd_addr + ADDR_WIDTH'(4);
                        if (cmd_cnt != {CNT_WIDTH{1'b1}}) begin
                            cmd_cnt <= cmd_cnt + CNT_WIDTH'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
            if (set_err) begin
                err_code <= err_val;
            end
        end
    end

endmodule

// File: tb/tb_cmd_executor.sv
// tb/tb_cmd_executor.sv - self-checking bench for cmd_executor
module tb_cmd_executor;

    localparam int          NENT     = 296;
    localparam logic [31:0] END_ADDR = 32'h0000_04A0;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  err_code;
    logic [7:0]  cmd_cnt;
    logic        cmd_rd_en;
    logic [31:0] cmd_addr;
    logic        cmd_rd_valid = 1'b0;
    logic [63:0] cmd_out = '0;
    logic        mst_o_valid;
    logic [31:0] mst_o_addr;
    logic [31:0] mst_o_wr_data;
    logic        mst_o_rd0_wr1;
    logic        mst_i_ready = 1'b0;
    logic [31:0] mst_i_rd_data = '0;
    logic        mst_i_rd_valid = 1'b0;

    cmd_executor #(
        .CMD_WIDTH (64),
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .END_ADDR  (END_ADDR),
        .CNT_WIDTH (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .err_code      (err_code),
        .cmd_cnt       (cmd_cnt),
        .cmd_rd_en     (cmd_rd_en),
        .cmd_addr      (cmd_addr),
        .cmd_rd_valid  (cmd_rd_valid),
        .cmd_out       (cmd_out),
        .mst_o_valid   (mst_o_valid),
        .mst_o_addr    (mst_o_addr),
        .mst_o_wr_data (mst_o_wr_data),
        .mst_o_rd0_wr1 (mst_o_rd0_wr1),
        .mst_i_ready   (mst_i_ready),
        .mst_i_rd_data (mst_i_rd_data),
        .mst_i_rd_valid(mst_i_rd_valid)
    );

    always #5 clk = ~clk;

    logic [111:0] all_outs;
    assign all_outs = {busy, done, err, err_code, cmd_cnt, cmd_rd_en, cmd_addr,
                       mst_o_valid, mst_o_addr, mst_o_wr_data, mst_o_rd0_wr1};

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0] mem [NENT];
    logic [31:0] rd_mem [logic [31:0]];
    txn_t        exp_q[$];
    txn_t        obs_q[$];
    bit          exp_err;
    logic [1:0]  exp_code;
    logic [7:0]  exp_cnt;

    bit          fetch_pend = 0;
    logic [63:0] fetch_word = '0;
    logic [31:0] last_fetch = '0;
    int          bad_fetch = 0;
    int          rd_wait = 0;
    int          rd_min = 1;
    logic [31:0] rd_resp = '0;
    int          stall_pct = 0;
    int          stall_left = 0;
    bit          glitch_mode = 0;
    bit          held = 0;
    bit          after_acc = 0;
    logic [64:0] held_val = '0;
    logic [64:0] cur;
    int          stab_err = 0;
    int          drop_err = 0;
    int          stall_cyc = 0;
    int          ncyc = 0;
    int          first_valid_k = -1;
    logic        rd_en_n1 = 1'b0;
    txn_t        mt;

    function automatic logic [31:0] rdval(input logic [31:0] a);
        return rd_mem.exists(a) ? rd_mem[a] : 32'h0;
    endfunction

    // command buffer and bus slave, driven away from the active edge
    always @(negedge clk) begin
        ncyc++;
        cmd_rd_valid = fetch_pend;
        cmd_out = fetch_pend ? fetch_word : {$urandom, $urandom};
        fetch_pend = 1'b0;
        if (rst_n && cmd_rd_en) begin
            fetch_pend = 1'b1;
            last_fetch = cmd_addr;
            if (cmd_addr >= END_ADDR || cmd_addr[1:0] != 2'b00) bad_fetch++;
            fetch_word = (cmd_addr < END_ADDR) ? mem[int'(cmd_addr >> 2)] : 64'h0;
        end
        mst_i_rd_valid = 1'b0;
        mst_i_rd_data = $urandom;
        if (rd_wait > 0) begin
            rd_wait--;
            if (rd_wait == 0) begin
                mst_i_rd_valid = 1'b1;
                mst_i_rd_data = rd_resp;
            end
        end
        if (rst_n && after_acc && mst_o_valid) drop_err++;
        if (mst_o_valid && stall_left > 0) begin
            mst_i_ready = 1'b0;
            stall_left--;
        end else begin
            mst_i_ready = ($urandom_range(0, 99) >= stall_pct);
        end
        after_acc = 1'b0;
        if (rst_n && mst_o_valid) begin
            cur = {mst_o_rd0_wr1, mst_o_addr, mst_o_wr_data};
            if (held && cur != held_val) stab_err++;
            held = 1'b1;
            held_val = cur;
            if (!mst_i_ready) begin
                stall_cyc++;
            end else begin
                mt.wr = mst_o_rd0_wr1;
                mt.addr = mst_o_addr;
                mt.data = mst_o_wr_data;
                mt.cyc = ncyc;
                obs_q.push_back(mt);
                held = 1'b0;
                after_acc = 1'b1;
                if (!mst_o_rd0_wr1) begin
                    rd_wait = rd_min + int'($urandom_range(0, 3));
                    rd_resp = rdval(mst_o_addr);
                    if (glitch_mode) begin
                        mst_i_rd_valid = 1'b1;
                        mst_i_rd_data = ~rd_resp;
                    end
                end
            end
        end else begin
            held = 1'b0;
        end
    end

    task automatic clear_tables();
        for (int i = 0; i < NENT; i++) mem[i] = 64'h0;
        rd_mem.delete();
    endtask

    // walk the command table by the decoding rules and list the bus traffic and outcome
    task automatic build_model();
        bit          pend = 0;
        logic [31:0] tmp = '0;
        int          cnt = 0;
        int          i = 0;
        bit          stop = 0;
        logic [63:0] c;
        logic [31:0] a;
        logic [31:0] d;
        txn_t        t;
        exp_q.delete();
        exp_err = 0;
        exp_code = 2'b00;
        while (!stop) begin
            if (i == NENT) begin
                exp_err = pend;
                exp_code = pend ? 2'b10 : 2'b00;
                stop = 1;
            end else begin
                c = mem[i];
                a = {c[63:34], 2'b00};
                d = c[33:2];
                if (c == 64'h0) begin
                    exp_err = pend;
                    exp_code = pend ? 2'b10 : 2'b00;
                    stop = 1;
                end else if (c[1:0] >= 2'd2) begin
                    exp_err = 1;
                    exp_code = 2'b01;
                    stop = 1;
                end else if (c[1:0] == 2'd1) begin
                    if (pend) begin
                        exp_err = 1;
                        exp_code = 2'b10;
                        stop = 1;
                    end else begin
                        t = '{wr: 1'b0, addr: a, data: 32'h0, cyc: 0};
                        exp_q.push_back(t);
                        tmp = rdval(a) & d;
                        pend = 1;
                    end
                end else begin
                    t = '{wr: 1'b1, addr: a, data: (pend ? (tmp | d) : d), cyc: 0};
                    exp_q.push_back(t);
                    pend = 0;
                    if (cnt < 255) cnt++;
                end
                i++;
            end
        end
        exp_cnt = 8'(cnt);
    endtask

    task automatic run_table(input int stall, input bit glitch, input bit poke, input string tag);
        bit         finished = 0;
        bit         got_done = 0;
        bit         got_err = 0;
        logic [1:0] got_code = 2'b00;
        logic [7:0] got_cnt = 8'h0;
        logic       busy_a;
        logic       busy_b;
        int         nmin;
        build_model();
        obs_q.delete();
        stab_err = 0;
        drop_err = 0;
        bad_fetch = 0;
        stall_cyc = 0;
        first_valid_k = -1;
        stall_pct = stall;
        glitch_mode = glitch;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rd_en_n1 = cmd_rd_en;
        for (int k = 0; k < 20000 && !finished; k++) begin
            @(negedge clk);
            start = poke && (k % 7 == 3);
            if (first_valid_k < 0 && mst_o_valid) first_valid_k = k;
            if (done || err) begin
                finished = 1;
                got_done = done;
                got_err = err;
                got_code = err_code;
                got_cnt = cmd_cnt;
                start = poke;
            end
        end
        @(negedge clk);
        start = 1'b0;
        busy_a = busy;
        @(negedge clk);
        busy_b = busy;
        n_cmp++;
        if (!finished) begin
            n_bad++;
            $display("FAIL %s timeout: no done/err within 20000 cycles, required one", tag);
        end
        n_cmp++;
        if ({got_done, got_err} !== (exp_err ? 2'b01 : 2'b10)) begin
            n_bad++;
            $display("FAIL %s outcome: done=%0b err=%0b, required done=%0b err=%0b",
                     tag, got_done, got_err, !exp_err, exp_err);
        end
        n_cmp++;
        if (got_code !== exp_code) begin
            n_bad++;
            $display("FAIL %s err_code: got %b, required %b", tag, got_code, exp_code);
        end
        n_cmp++;
        if (got_cnt !== exp_cnt) begin
            n_bad++;
            $display("FAIL %s cmd_cnt: got %0d, required %0d", tag, got_cnt, exp_cnt);
        end
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL %s txn_count: got %0d, required %0d", tag, obs_q.size(), exp_q.size());
        end
        nmin = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < nmin; i++) begin
            n_cmp++;
            if (obs_q[i].wr !== exp_q[i].wr || obs_q[i].addr !== exp_q[i].addr ||
                (exp_q[i].wr && obs_q[i].data !== exp_q[i].data)) begin
                n_bad++;
                $display("FAIL %s txn[%0d]: got wr=%b addr=%h data=%h, required wr=%b addr=%h data=%h",
                         tag, i, obs_q[i].wr, obs_q[i].addr, obs_q[i].data,
                         exp_q[i].wr, exp_q[i].addr, exp_q[i].data);
            end
        end
        n_cmp++;
        if (stab_err != 0 || drop_err != 0 || bad_fetch != 0) begin
            n_bad++;
            $display("FAIL %s protocol: unstable=%0d no_drop=%0d bad_fetch=%0d, required all 0",
                     tag, stab_err, drop_err, bad_fetch);
        end
        n_cmp++;
        if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
            n_bad++;
            $display("FAIL %s idle_after_end: busy=%b%b, required 00 (late start ignored)",
                     tag, busy_a, busy_b);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (all_outs !== 112'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h, required 0", all_outs);
        end
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || cmd_rd_en !== 1'b0 || mst_o_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle: busy=%b rd_en=%b valid=%b, required 0 0 0",
                     busy, cmd_rd_en, mst_o_valid);
        end
    endtask

    task automatic test_single_write();
        clear_tables();
        mem[0] = {30'h0000_0100, 32'hDEAD_BEEF, 2'b00};
        run_table(0, 1'b0, 1'b0, "single_write");
        n_cmp++;
        if (rd_en_n1 !== 1'b1) begin
            n_bad++;
            $display("FAIL rd_en_latency: cmd_rd_en at N+1 = %b, required 1", rd_en_n1);
        end
        n_cmp++;
        if (first_valid_k != 2) begin
            n_bad++;
            $display("FAIL valid_latency: first mst_o_valid at N+%0d, required N+4", first_valid_k + 2);
        end
        n_cmp++;
        if (obs_q.size() != 1 || obs_q[0].wr !== 1'b1 || obs_q[0].addr !== 32'h0000_0400 ||
            obs_q[0].data !== 32'hDEAD_BEEF) begin
            n_bad++;
            $display("FAIL single_write_txn: got %0d txns, required one write 400 <- DEADBEEF",
                     obs_q.size());
        end
        n_cmp++;
        if (cmd_cnt !== 8'd1) begin
            n_bad++;
            $display("FAIL single_write_cnt: got %0d, required 1", cmd_cnt);
        end
    endtask

    task automatic test_rmw_write();
        clear_tables();
        mem[0] = {30'h0000_0004, 32'h0000_FF00, 2'b01};
        mem[1] = {30'h0000_0004, 32'h0000_0001, 2'b00};
        rd_mem[32'h10] = 32'h1234_5678;
        run_table(20, 1'b1, 1'b0, "rmw_write");
        n_cmp++;
        if (obs_q.size() != 2 || obs_q[0].wr !== 1'b0 || obs_q[0].addr !== 32'h10 ||
            obs_q[1].wr !== 1'b1 || obs_q[1].addr !== 32'h10 || obs_q[1].data !== 32'h0000_5601) begin
            n_bad++;
            $display("FAIL rmw_write_txn: got %0d txns (last data %h), required read 10 then write 10 <- 00005601",
                     obs_q.size(), (obs_q.size() > 0) ? obs_q[obs_q.size()-1].data : 32'h0);
        end
    endtask

    task automatic test_illegal();
        clear_tables();
        mem[0] = {30'h0000_0020, 32'h0BAD_C0DE, 2'b10};
        run_table(0, 1'b0, 1'b0, "illegal");
        n_cmp++;
        if (obs_q.size() != 0 || err_code !== 2'b01) begin
            n_bad++;
            $display("FAIL illegal_code: txns=%0d err_code=%b, required 0 and 01", obs_q.size(), err_code);
        end
    endtask

    task automatic test_bad_seq();
        clear_tables();
        mem[0] = {30'h0000_0008, 32'h0000_00FF, 2'b01};
        mem[1] = {30'h0000_0009, 32'h0000_0F0F, 2'b01};
        rd_mem[32'h20] = 32'hCAFE_F00D;
        run_table(10, 1'b0, 1'b0, "rmw_rmw");
        n_cmp++;
        if (obs_q.size() != 1 || err_code !== 2'b10) begin
            n_bad++;
            $display("FAIL rmw_rmw: txns=%0d err_code=%b, required 1 and 10", obs_q.size(), err_code);
        end
        clear_tables();
        mem[0] = {30'h0000_0008, 32'h0000_00FF, 2'b01};
        run_table(0, 1'b0, 1'b0, "rmw_zero");
        n_cmp++;
        if (err_code !== 2'b10) begin
            n_bad++;
            $display("FAIL rmw_zero: err_code=%b, required 10", err_code);
        end
    endtask

    task automatic test_backpressure();
        clear_tables();
        mem[0] = {30'h0000_0040, 32'h1357_9BDF, 2'b00};
        mem[1] = {30'h0000_0041, 32'h2468_ACE0, 2'b00};
        stall_left = 5;
        run_table(0, 1'b0, 1'b0, "backpressure");
        n_cmp++;
        if (stall_cyc != 5 || stab_err != 0) begin
            n_bad++;
            $display("FAIL backpressure: stalled=%0d unstable=%0d, required 5 and 0", stall_cyc, stab_err);
        end
    endtask

    task automatic test_back_to_back();
        int bad_gap = 0;
        clear_tables();
        for (int i = 0; i < NENT; i++) begin
            mem[i] = {$urandom, $urandom};
            mem[i][1:0] = 2'b00;
            if (mem[i] == 64'h0) mem[i][2] = 1'b1;
        end
        run_table(0, 1'b0, 1'b0, "full_table");
        for (int i = 1; i < obs_q.size(); i++) begin
            if (obs_q[i].cyc - obs_q[i-1].cyc != 4) bad_gap++;
        end
        n_cmp++;
        if (bad_gap != 0) begin
            n_bad++;
            $display("FAIL back_to_back: %0d gaps differ, required 4 cycles per write", bad_gap);
        end
        n_cmp++;
        if (last_fetch !== 32'h0000_049C) begin
            n_bad++;
            $display("FAIL last_fetch: got %h, required 0000049c", last_fetch);
        end
        n_cmp++;
        if (cmd_cnt !== 8'd255) begin
            n_bad++;
            $display("FAIL cnt_saturate: got %0d, required 255", cmd_cnt);
        end
    endtask

    task automatic gen_random(input int len);
        logic [31:0] d;
        logic [1:0]  tr;
        logic [29:0] a30;
        int          r;
        bit          prev_rmw = 0;
        clear_tables();
        for (int i = 0; i < len; i++) begin
            r = int'($urandom_range(0, 99));
            a30 = 30'($urandom_range(0, 63));
            d = $urandom;
            if (prev_rmw && r < 85) tr = 2'b00;
            else if (r < 6) tr = 2'b10;
            else if (r < 10) tr = 2'b11;
            else if (r < 40) tr = 2'b01;
            else tr = 2'b00;
            mem[i] = {a30, d, tr};
            if (mem[i] == 64'h0) mem[i][2] = 1'b1;
            prev_rmw = (tr == 2'b01);
            if (!rd_mem.exists({a30, 2'b00})) rd_mem[{a30, 2'b00}] = $urandom;
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 12; it++) begin
            gen_random(int'($urandom_range(1, 24)));
            stall_left = 0;
            run_table(int'($urandom_range(0, 50)), 1'($urandom_range(0, 1)), 1'b1, "random");
        end
    endtask

    task automatic test_abort();
        bit found = 0;
        int events = 0;
        clear_tables();
        mem[0] = {30'h0000_0030, 32'h0000_00AA, 2'b00};
        mem[1] = {30'h0000_0031, 32'h0000_FFFF, 2'b01};
        mem[2] = {30'h0000_0031, 32'h0000_0100, 2'b00};
        rd_mem[32'hC4] = 32'h8765_4321;
        obs_q.delete();
        stall_pct = 0;
        stall_left = 0;
        glitch_mode = 0;
        rd_min = 8;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            start = (k == 2);
            if (obs_q.size() == 2 && busy && !mst_o_valid && !cmd_rd_en) found = 1;
        end
        start = 1'b0;
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL abort_reach_wait_rd: read not outstanding within 200 cycles, required it");
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (all_outs !== 112'h0) begin
            n_bad++;
            $display("FAIL abort_reset_outputs: got %h, required 0", all_outs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (busy || done || err || cmd_rd_en || mst_o_valid) events++;
        end
        n_cmp++;
        if (events != 0 || obs_q.size() != 2) begin
            n_bad++;
            $display("FAIL abort_quiet: activity cycles=%0d txns=%0d, required 0 and 2",
                     events, obs_q.size());
        end
        rd_min = 1;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_rmw_write();
        test_illegal();
        test_bad_seq();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cmd_executor.md
# cmd_executor

Command executor for the GP engine; the reader and consumer of the command buffer. On `start` it fetches 64-bit commands from the buffer one at a time over the buffer's FSM read port, decodes them, and issues the resulting WRITE or read-modify-write bus transactions on a valid/ready master port. It stops at an all-zero entry or at the end address, and reports completion or a sequencing error to the control/status registers.

## Interface
- `CMD_WIDTH`, 64: command width.
- `ADDR_WIDTH`, 32: command index and bus address width.
- `DATA_WIDTH`, 32: bus data width.
- `END_ADDR`, 32'h0000_04A0: first `cmd_addr` value that is never fetched.
- `CNT_WIDTH`, 8: width of `cmd_cnt`.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse that begins execution. Ignored unless the block is IDLE.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse on normal completion.
- `err` out 1: one-cycle pulse on abnormal termination.
- `err_code` out 2: 01 = illegal transaction code; 10 = RWM not followed by WRITE. Held until the next `start`.
- `cmd_cnt` out CNT_WIDTH: number of bus writes completed in the current run. Saturates at its maximum value.
- `cmd_rd_en` out 1: fetch request to the command buffer.
- `cmd_addr` out ADDR_WIDTH: fetch index. Starts at 0 and steps by 4.
- `cmd_rd_valid` in 1: fetch data valid. Arrives 1 cycle after `cmd_rd_en`.
- `cmd_out` in CMD_WIDTH: fetched command.
- `mst_o_valid` out 1: bus request valid.
- `mst_o_addr` out ADDR_WIDTH: bus address.
- `mst_o_wr_data` out DATA_WIDTH: bus write data.
- `mst_o_rd0_wr1` out 1: 1 = write, 0 = read.
- `mst_i_ready` in 1: the bus accepts the request.
- `mst_i_rd_data` in DATA_WIDTH: read data.
- `mst_i_rd_valid` in 1: read data valid.

## Operation
- Command fields:
  - `trans` = `cmd_out[1:0]`.
  - `data` = `cmd_out[33:2]`.
  - `addr` = {`cmd_out[63:34]`, 2'b00}.
  - `trans` encoding: 00 = WRITE, 01 = RWM; 10 and 11 are illegal.
- States: IDLE, FETCH, WAIT_CMD, DECODE, ISSUE_WR, ISSUE_RD, WAIT_RD, DONE, ERROR.
- IDLE:
  - On `start`: clear `cmd_addr`, `cmd_cnt`, `err_code` and the `rmw_pend` flag, then go to FETCH.
- FETCH:
  - If `cmd_addr` == END_ADDR: go to ERROR (code 10) if `rmw_pend` is set, otherwise go to DONE.
  - Otherwise assert `cmd_rd_en` for exactly one cycle and go to WAIT_CMD.
- WAIT_CMD:
  - Stay until `cmd_rd_valid` is seen.
  - Latch `cmd_out` into the command register, then go to DECODE.
- DECODE:
  - All-zero command: go to ERROR (code 10) if `rmw_pend`, otherwise go to DONE.
  - Illegal `trans`: go to ERROR (code 01).
  - RWM while `rmw_pend` is set: go to ERROR (code 10).
  - RWM otherwise: go to ISSUE_RD.
  - WRITE: go to ISSUE_WR.
- ISSUE_RD:
  - Drive `mst_o_valid`=1, `mst_o_rd0_wr1`=0, `mst_o_addr`=addr.
  - On accept, go to WAIT_RD.
- WAIT_RD:
  - On `mst_i_rd_valid`: set `tmp` = `mst_i_rd_data` & `data` (the RWM data is an AND mask).
  - Set `rmw_pend`, set `cmd_addr` += 4, go to FETCH.
- ISSUE_WR:
  - Drive `mst_o_valid`=1, `mst_o_rd0_wr1`=1, `mst_o_addr`=addr.
  - Write data is (`tmp` | `data`) if `rmw_pend` is set, otherwise `data`.
  - On accept: clear `rmw_pend`, `cmd_cnt`++, `cmd_addr` += 4, go to FETCH.
- DONE: assert `done` for one cycle, go to IDLE.
- ERROR: assert `err` for one cycle and set `err_code`, go to IDLE.
- Arithmetic: `cmd_addr` adds are modulo 2^ADDR_WIDTH. END_ADDR is checked before every fetch, so wrap-around is unreachable.

## Timing
- Reset values: all outputs 0, `cmd_addr` 0, state IDLE; `tmp`, the command register and `rmw_pend` are cleared.
- Reset mid-run: the block returns to IDLE immediately. It neither issues nor completes any further bus request, and emits no `done` or `err`.
- Start and fetch latency:
  - `start` sampled in cycle N.
  - `cmd_rd_en` high in N+1.
  - `cmd_rd_valid` in N+2.
  - DECODE in N+3.
  - `mst_o_valid` first high in N+4.
- Request handshake:
  - A request is accepted in a cycle where `mst_o_valid` && `mst_i_ready`.
  - `mst_o_valid`, address, data and direction are held stable until accepted.
  - `mst_o_valid` drops in the cycle after acceptance.
  - At most one request is outstanding at a time.
- `mst_i_rd_valid` is sampled only in WAIT_RD; if it arrives in the same cycle as accept, it is ignored.
- Back-to-back WRITEs with `mst_i_ready` held at 1: 4 cycles per command (FETCH, WAIT_CMD, DECODE, ISSUE_WR).
- `start` is ignored in every state other than IDLE, including the DONE and ERROR cycles.
- `done` and `err` are never asserted in the same cycle.

## Test plan
- Single WRITE:
  - Stimulus: entry 0 = {30'h0000_0100, 32'hDEAD_BEEF, 2'b00}, entry 4 = 0, `start`.
  - Required: one write to 0x400 with data DEAD_BEEF, then `done`; `cmd_cnt` = 1; first `mst_o_valid` at N+4.
- RWM then WRITE:
  - Stimulus: RWM to 0x10 with mask 0000_FF00; read returns 1234_5678; following WRITE to 0x10 with data 0000_0001.
  - Required: read of 0x10, then write of 0000_5601 to 0x10; `done`.
- Illegal code:
  - Stimulus: entry 0 with `trans` = 2'b10.
  - Required: no bus request, `err` pulse, `err_code` = 01.
- Bad sequencing:
  - Stimulus: RWM followed by RWM.
  - Required: one read only, `err_code` = 10.
  - Stimulus: RWM followed by an all-zero entry.
  - Required: `err_code` = 10.
- Backpressure and end:
  - Stimulus: `mst_i_ready` low for 5 cycles during a write.
  - Required: request held stable throughout the stall.
  - Stimulus: full table of 296 non-zero WRITEs.
  - Required: the last fetch is at 0x49C, `done` follows, `cmd_cnt` = 255 (saturated).
- Abort:
  - Stimulus: `start` pulsed while busy; `rst_n` asserted during WAIT_RD.
  - Required: the `start` pulse has no effect; after the reset, all outputs are 0 and the block is IDLE.
